// File: rtl/trap_pkg.sv
// Shared constants for the trap controller: exception codes, CSR addresses,
// controller state encoding and STATUS/CAUSE field positions.
package trap_pkg;

  localparam logic [4:0] EXC_IRQ   = 5'd0;
  localparam logic [4:0] EXC_DIV0  = 5'd7;
  localparam logic [4:0] EXC_SYS   = 5'd8;
  localparam logic [4:0] EXC_BRK   = 5'd9;
  localparam logic [4:0] EXC_UNDEF = 5'd10;
  localparam logic [4:0] EXC_OVF   = 5'd12;

  localparam logic [4:0] CSR_STATUS = 5'd12;
  localparam logic [4:0] CSR_CAUSE  = 5'd13;
  localparam logic [4:0] CSR_EPC    = 5'd14;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } state_e;

  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_IM_LSB = 8;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 8;

  localparam logic [31:0] VEC_IRQ_OFS = 32'h0000_0200;

endpackage

// File: rtl/trap_controller_irq_sync.sv
// NUM_IRQ-wide, SYNC_STAGES-deep flop chain bringing the asynchronous
// interrupt lines into the clk domain.
module irq_sync #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic [NUM_IRQ-1:0] irq_sync_o
);

  logic [NUM_IRQ-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= irq_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign irq_sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/trap_controller.sv
// CP0-style exception/interrupt controller: STATUS/CAUSE/EPC, trap and eret
// redirects. Define VECTORED_IRQ_EN to give each interrupt its own vector.
module trap_controller
  import trap_pkg::*;
#(
  parameter int               NUM_IRQ     = 8,
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  VEC_BASE    = 32'h0000_0080,
  parameter int               SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               exc_undef_i,
  input  logic               exc_syscall_i,
  input  logic               exc_break_i,
  input  logic               exc_div0_i,
  input  logic               exc_overflow_i,
  input  logic               eret_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [XLEN-1:0]    pc_plus4_i,
  input  logic               csr_we_i,
  input  logic [4:0]         csr_addr_i,
  input  logic [XLEN-1:0]    csr_wdata_i,
  output logic [XLEN-1:0]    csr_rdata_o,
  output logic               trap_taken_o,
  output logic [XLEN-1:0]    trap_vector_o,
  output logic               eret_taken_o,
  output logic [XLEN-1:0]    epc_out_o
);

  state_e             state_q;
  logic               ie_q;
  logic [NUM_IRQ-1:0] im_q;
  logic [NUM_IRQ-1:0] ip_q, ip_d;
  logic [4:0]         exccode_q;
  logic [XLEN-1:0]    epc_q;

  logic [NUM_IRQ-1:0] irq_sync;
  logic [NUM_IRQ-1:0] irq_pend;
  logic [NUM_IRQ-1:0] ip_clr;
  logic               sync_exc;
  logic               irq_req;
  logic [4:0]         exc_code;
  logic [4:0]         irq_idx;
  logic               status_we, cause_we, epc_we;

  irq_sync #(
    .NUM_IRQ    (NUM_IRQ),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_i     (irq_i),
    .irq_sync_o(irq_sync)
  );

  assign status_we = csr_we_i && (csr_addr_i == CSR_STATUS);
  assign cause_we  = csr_we_i && (csr_addr_i == CSR_CAUSE);
  assign epc_we    = csr_we_i && (csr_addr_i == CSR_EPC);

  // W1C clear of pending bits; a newly synchronised request overrides the clear.
  assign ip_clr = cause_we ? csr_wdata_i[CAUSE_IP_LSB +: NUM_IRQ] : '0;
  assign ip_d   = (ip_q & ~ip_clr) | irq_sync;

  assign irq_pend = ip_q & im_q;
  assign sync_exc = exc_undef_i | exc_syscall_i | exc_break_i | exc_div0_i | exc_overflow_i;
  assign irq_req  = (state_q == ST_RUN) && ie_q && (|irq_pend);

  assign trap_taken_o = sync_exc | irq_req;
  assign eret_taken_o = eret_i && (state_q == ST_HANDLER) && !sync_exc;
  assign epc_out_o    = epc_q;

  always_comb begin
    exc_code = EXC_IRQ;
    if (exc_undef_i)         exc_code = EXC_UNDEF;
    else if (exc_syscall_i)  exc_code = EXC_SYS;
    else if (exc_break_i)    exc_code = EXC_BRK;
    else if (exc_div0_i)     exc_code = EXC_DIV0;
    else if (exc_overflow_i) exc_code = EXC_OVF;
  end

  // Scan downwards so the lowest pending index is the last one written.
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) irq_idx = 5'(i);
    end
  end

`ifdef VECTORED_IRQ_EN
  always_comb begin
    trap_vector_o = VEC_BASE;
    if (!sync_exc && irq_req)
      trap_vector_o = VEC_BASE + XLEN'(VEC_IRQ_OFS) + XLEN'({irq_idx, 2'b00});
  end
`else
  assign trap_vector_o = VEC_BASE;
`endif

  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_STATUS: begin
        csr_rdata_o[STATUS_IE]                   = ie_q;
        csr_rdata_o[STATUS_EXL]                  = (state_q == ST_HANDLER);
        csr_rdata_o[STATUS_IM_LSB +: NUM_IRQ]    = im_q;
      end
      CSR_CAUSE: begin
        csr_rdata_o[CAUSE_EXC_LSB +: 5]          = exccode_q;
        csr_rdata_o[CAUSE_IP_LSB +: NUM_IRQ]     = ip_q;
      end
      CSR_EPC:   csr_rdata_o = epc_q;
      default:   csr_rdata_o = '0;
    endcase
  end

  // EXL is the state bit itself; later assignments give trap > eret > CSR write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      ie_q      <= 1'b0;
      im_q      <= '0;
      ip_q      <= '0;
      exccode_q <= EXC_IRQ;
      epc_q     <= '0;
    end else begin
      ip_q <= ip_d;
      if (status_we) begin
        ie_q    <= csr_wdata_i[STATUS_IE];
        im_q    <= csr_wdata_i[STATUS_IM_LSB +: NUM_IRQ];
        state_q <= csr_wdata_i[STATUS_EXL] ? ST_HANDLER : ST_RUN;
      end
      if (epc_we) epc_q <= csr_wdata_i;
      if (eret_taken_o) state_q <= ST_RUN;
      if (trap_taken_o) begin
        exccode_q <= exc_code;
        state_q   <= ST_HANDLER;
        if (state_q == ST_RUN) epc_q <= sync_exc ? pc_i : pc_plus4_i;
      end
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: CSR reset state, sync exceptions,
// interrupt latency, handler nesting, eret, W1C of IP and mid-handler reset.
module tb_trap_controller;

  localparam int          NUM_IRQ  = 8;
  localparam int          XLEN     = 32;
  localparam logic [31:0] VEC_BASE = 32'h0000_0080;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_IRQ-1:0] irq;
  logic               exc_undef, exc_syscall, exc_break, exc_div0, exc_overflow;
  logic               eret;
  logic [XLEN-1:0]    pc, pc_plus4;
  logic               csr_we;
  logic [4:0]         csr_addr;
  logic [XLEN-1:0]    csr_wdata;
  logic [XLEN-1:0]    csr_rdata;
  logic               trap_taken;
  logic [XLEN-1:0]    trap_vector;
  logic               eret_taken;
  logic [XLEN-1:0]    epc_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] irq_vec0;

  trap_controller #(
    .NUM_IRQ    (NUM_IRQ),
    .XLEN       (XLEN),
    .VEC_BASE   (VEC_BASE),
    .SYNC_STAGES(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .irq_i         (irq),
    .exc_undef_i   (exc_undef),
    .exc_syscall_i (exc_syscall),
    .exc_break_i   (exc_break),
    .exc_div0_i    (exc_div0),
    .exc_overflow_i(exc_overflow),
    .eret_i        (eret),
    .pc_i          (pc),
    .pc_plus4_i    (pc_plus4),
    .csr_we_i      (csr_we),
    .csr_addr_i    (csr_addr),
    .csr_wdata_i   (csr_wdata),
    .csr_rdata_o   (csr_rdata),
    .trap_taken_o  (trap_taken),
    .trap_vector_o (trap_vector),
    .eret_taken_o  (eret_taken),
    .epc_out_o     (epc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic read_csr(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    csr_addr = addr;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic write_csr(input logic [4:0] addr, input logic [31:0] data);
    csr_we    = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    step();
    csr_we    = 1'b0;
    csr_wdata = '0;
  endtask

  initial begin
`ifdef VECTORED_IRQ_EN
    irq_vec0 = 32'h0000_0280;
`else
    irq_vec0 = VEC_BASE;
`endif
    rst_n = 1'b0; irq = '0;
    exc_undef = 0; exc_syscall = 0; exc_break = 0; exc_div0 = 0; exc_overflow = 0;
    eret = 0; pc = '0; pc_plus4 = '0;
    csr_we = 0; csr_addr = '0; csr_wdata = '0;
    #12;

    // Reset state
    read_csr(5'd12, 32'h0, "rst_status");
    read_csr(5'd13, 32'h0, "rst_cause");
    read_csr(5'd14, 32'h0, "rst_epc");
    check("rst_vector", trap_vector, VEC_BASE);
    check("rst_trap", {31'b0, trap_taken}, 32'h0);
    check("rst_epc_out", epc_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Syscall in RUN
    pc = 32'h40; pc_plus4 = 32'h44; exc_syscall = 1;
    #1;
    check("sys_trap", {31'b0, trap_taken}, 32'h1);
    check("sys_vector", trap_vector, VEC_BASE);
    step();
    exc_syscall = 0;
    read_csr(5'd13, 32'h20, "sys_cause");
    read_csr(5'd14, 32'h40, "sys_epc");
    read_csr(5'd12, 32'h2, "sys_status");

    // Overflow inside handler keeps EPC
    pc = 32'h60; pc_plus4 = 32'h64; exc_overflow = 1;
    #1;
    check("ovf_trap", {31'b0, trap_taken}, 32'h1);
    step();
    exc_overflow = 0;
    read_csr(5'd13, 32'h30, "ovf_cause");
    check("ovf_epc", epc_out, 32'h40);

    // eret together with break: exception wins
    eret = 1; exc_break = 1;
    #1;
    check("brk_eret_trap", {31'b0, trap_taken}, 32'h1);
    check("brk_eret_ign", {31'b0, eret_taken}, 32'h0);
    step();
    exc_break = 0;
    read_csr(5'd13, 32'h24, "brk_cause");
    read_csr(5'd12, 32'h2, "brk_status");

    // Plain eret
    #1;
    check("eret_taken", {31'b0, eret_taken}, 32'h1);
    check("eret_epc", epc_out, 32'h40);
    check("eret_notrap", {31'b0, trap_taken}, 32'h0);
    step();
    eret = 0;
    read_csr(5'd12, 32'h0, "eret_status");

    // eret in RUN is ignored
    eret = 1;
    #1;
    check("eret_run", {31'b0, eret_taken}, 32'h0);
    step();
    eret = 0;

    // Interrupt latency and trap
    write_csr(5'd12, 32'h0000_0301);
    read_csr(5'd12, 32'h301, "ie_status");
    pc = 32'h100; pc_plus4 = 32'h104;
    irq = 8'h03;
    step();
    #1;
    check("irq_edge1", {31'b0, trap_taken}, 32'h0);
    step();
    #1;
    check("irq_edge2", {31'b0, trap_taken}, 32'h0);
    step();
    #1;
    check("irq_edge3", {31'b0, trap_taken}, 32'h1);
    check("irq_vector", trap_vector, irq_vec0);
    read_csr(5'd13, 32'h324, "irq_cause_pre");
    step();
    read_csr(5'd13, 32'h300, "irq_cause");
    read_csr(5'd14, 32'h104, "irq_epc");
    read_csr(5'd12, 32'h303, "irq_status");
    irq = 8'h01;
    #1;
    check("irq_blocked", {31'b0, trap_taken}, 32'h0);

    // W1C while irq0 still high: set wins
    write_csr(5'd13, 32'h100);
    read_csr(5'd13, 32'h300, "w1c_setwins");
    irq = 8'h00;
    step();
    step();
    write_csr(5'd13, 32'h100);
    read_csr(5'd13, 32'h200, "w1c_ip0");
    write_csr(5'd13, 32'h200);
    read_csr(5'd13, 32'h000, "w1c_ip1");

    // EPC write, then leave handler
    write_csr(5'd14, 32'h300);
    check("epc_write", epc_out, 32'h300);
    eret = 1;
    step();
    eret = 0;
    read_csr(5'd12, 32'h301, "ret_status");

    // Undef + overflow + pending irq: undef wins
    irq = 8'h01;
    step(); step(); step();
    #1;
    check("pend_trap", {31'b0, trap_taken}, 32'h1);
    pc = 32'h200; pc_plus4 = 32'h204;
    exc_undef = 1; exc_overflow = 1;
    #1;
    check("undef_vector", trap_vector, VEC_BASE);
    step();
    exc_undef = 0; exc_overflow = 0; irq = 8'h00;
    read_csr(5'd13, 32'h128, "undef_cause");
    read_csr(5'd14, 32'h200, "undef_epc");

    // Reset in HANDLER clears everything
    rst_n = 1'b0;
    #1;
    read_csr(5'd12, 32'h0, "mid_rst_status");
    read_csr(5'd13, 32'h0, "mid_rst_cause");
    read_csr(5'd14, 32'h0, "mid_rst_epc");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    read_csr(5'd13, 32'h0, "post_rst_cause");
    check("post_rst_trap", {31'b0, trap_taken}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
